// File: rtl/reg_file_if.sv
// Bundle of the writeback write port and the decode-stage dual read port
// for the integer register file.
interface reg_file_if #(
    parameter int BITS   = 64,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BITS-1:0]   wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [BITS-1:0]   rs1_data;
    logic [BITS-1:0]   rs2_data;
    logic              rd_valid;

    // Pipeline side: issues writes and read requests, consumes read data.
    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, rd_valid
    );

    // Register file side.
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, rd_valid
    );
endinterface

// File: rtl/reg_file_reader.sv
// RISC-V integer register file: one write port, two registered read ports, x0 reads zero.
// Define REG_FILE_BYPASS_EN to forward same-edge write data to a matching read port.
module reg_file_reader #(
    parameter int BITS   = 64,
    parameter int ADDR_W = 5
) (
    input logic        clk,
    input logic        rst,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [BITS-1:0] regs [DEPTH];
    logic [BITS-1:0] rs1_next;
    logic [BITS-1:0] rs2_next;
    logic [BITS-1:0] rs1_q;
    logic [BITS-1:0] rs2_q;
    logic            rd_valid_q;
    logic            wr_ok;

    assign wr_ok = bus.wr_en && (bus.wr_addr != '0);

    // NOTE: the storage array is cleared by reset on purpose; no entry may ever read X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // NOTE: each combinational output gets a default first so no path infers a latch.
    always_comb begin
        rs1_next = '0;
        rs2_next = '0;
        if (bus.rs1_addr != '0) begin
            rs1_next = regs[bus.rs1_addr];
        end
        if (bus.rs2_addr != '0) begin
            rs2_next = regs[bus.rs2_addr];
        end
`ifdef REG_FILE_BYPASS_EN
        // wr_ok already excludes x0, so address 0 is never forwarded.
        if (wr_ok && (bus.wr_addr == bus.rs1_addr)) begin
            rs1_next = bus.wr_data;
        end
        if (wr_ok && (bus.wr_addr == bus.rs2_addr)) begin
            rs2_next = bus.wr_data;
        end
`endif
    end

    // Data holds across rd_en=0 so a stalled decode stage keeps its operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rs1_q <= rs1_next;
                rs2_q <= rs2_next;
            end
        end
    end

    assign bus.rs1_data = rs1_q;
    assign bus.rs2_data = rs2_q;
    assign bus.rd_valid = rd_valid_q;
endmodule
